twos_to_signmag: RTL and testbench
==================================

# twos_to_signmag

Bit-serial decoder converting a WIDTH-bit two's-complement operand into sign and unsigned magnitude, i.e. undoing the ALU's negation stage. It sits on the ALU result path ahead of display and compare logic that needs |x| plus a sign flag. It uses one bit-serial datapath, copying bits LSB-first up to and including the first 1 and inverting the bits after it, plus a valid/ready handshake on each side.

## Interface
- WIDTH, 8, operand width in bits (≥2).

- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-high; one clock domain (clk).
- in_valid  input  1  operand present on `in`.
- in_ready  output  1  block can accept an operand; high exactly in IDLE.
- in  input  WIDTH  two's-complement operand, sampled on the accept edge.
- out_valid  output  1  result on sign/mag/zero is valid.
- out_ready  input  1  consumer accepts result.
- sign  output  1  1 if operand was negative (operand MSB).
- mag  output  WIDTH  unsigned magnitude |in|.
- zero  output  1  1 if operand was 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. If in_valid, then at the clock edge: load shift register ← in, sign_r ← in[WIDTH-1], seen_one ← 0, count ← 0, nz ← 0, and go to SHIFT.
- SHIFT: each cycle, take b = shreg[0].
  - out bit = sign_r & seen_one ? ~b : b.
  - Shift out bit into the work register from the MSB end (right-shift).
  - seen_one ← seen_one | b; nz ← nz | b; count ← count+1.
  - After WIDTH shift cycles (count = WIDTH-1 on the edge), go to DONE. On that same edge, load sign ← sign_r, mag ← final work value, zero ← ~nz.
- Positive operands take the same path with no inversion, so latency is fixed.
- DONE: out_valid=1. Go to IDLE on the edge where out_ready=1.
- in_valid outside IDLE is ignored. No operand is captured and the operand is not queued.
- Arithmetic rules:
  - mag is unsigned WIDTH bits, so the most-negative operand 2^(WIDTH-1) (0x80) gives sign=1, mag=0x80. There is no overflow flag.
  - Operand 0 gives sign=0, mag=0, zero=1.
- sign, mag and zero are registered. They change only on the edge entering DONE and hold their last result through IDLE/SHIFT until the next DONE entry.

## Timing
- Reset (async assert, any state):
  - state=IDLE.
  - in_ready=1, out_valid=0, sign=0, mag=0, zero=0.
  - Internal shift, work, count, seen_one and nz registers cleared.
- Reset mid-SHIFT or in DONE aborts the operation. The result is lost and no out_valid pulse occurs.
- Deassertion is synchronised externally; the block needs no special release cycle.
- Accept edge E0 (in_valid & in_ready). SHIFT occupies edges E1..E_WIDTH. out_valid rises after E_WIDTH: cycle WIDTH+1 for WIDTH=8, i.e. 8 clocks after accept.
- out_valid and outputs are stable until the out_ready edge. After that edge out_valid=0 and in_ready=1 in the next cycle.
- Minimum spacing between accepts is WIDTH+2 cycles (10 for WIDTH=8), reached when out_ready is held high.
- in_ready and out_valid are decoded from state only. There is no combinational path from in_valid or out_ready.

## Test plan
- Positive: in=0x05 accepted at E0 → out_valid high after E8; sign=0, mag=0x05, zero=0.
- Negative: in=0xFB → sign=1, mag=0x05. Also in=0xFF → sign=1, mag=0x01. Also in=0x81 → sign=1, mag=0x7F.
- Boundaries:
  - in=0x80 → sign=1, mag=0x80, zero=0.
  - in=0x00 → sign=0, mag=0x00, zero=1.
  - in=0x7F → sign=0, mag=0x7F.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles after out_valid.
  - out_valid, sign and mag stay constant and in_ready stays 0.
  - Pulse in_valid with 0x33 during SHIFT; it is not captured.
  - Raise out_ready; next cycle in_ready=1.
- Reset mid-operation: accept 0xFB, assert rst after E3.
  - Outputs immediately read out_valid=0, sign=0, mag=0, in_ready=1.
  - After release, accept 0x02 → sign=0, mag=0x02 after 8 cycles.
- Back-to-back: out_ready tied 1, in_valid tied 1 with operands 0xFE, 0x03, 0x80.
  - Results in order: (1,0x02), (0,0x03), (1,0x80).
  - Accepts are spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/twos_to_signmag.sv
// twos_to_signmag
// Bit-serial decoder that turns a WIDTH-bit two's-complement operand into a
// sign flag plus an unsigned magnitude. Bits are walked LSB-first: every bit
// up to and including the first 1 is copied, and for negative operands every
// later bit is inverted. Positive operands take the same walk without the
// inversion, so the latency never depends on the data.
// A valid/ready handshake sits on each side. sign/mag/zero are registered and
// keep the last result until the next one is produced.

module twos_to_signmag #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [WIDTH-1:0] mag,
    output logic             zero
);

    localparam int COUNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-2:0]   work;
    logic [COUNT_W-1:0] count;
    logic               sign_r;
    logic               seen_one;
    logic               nz;

    logic               cur_bit;
    logic               out_bit;
    logic [WIDTH-1:0]   shifted;
    logic               last_shift;

    // Per-cycle serial step: decide the outgoing bit and form the shifted work value
    always_comb begin
        cur_bit    = shreg[0];
        out_bit    = (sign_r & seen_one) ? ~cur_bit : cur_bit;
        shifted    = {out_bit, work};
        last_shift = (count == COUNT_W'(WIDTH - 1));
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, shift WIDTH cycles, hold result until consumed
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from state alone, with no path from the inputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: load the operand on accept, walk it serially, publish on the last shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            work     <= '0;
            count    <= '0;
            sign_r   <= 1'b0;
            seen_one <= 1'b0;
            nz       <= 1'b0;
            sign     <= 1'b0;
            mag      <= '0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in;
                        sign_r   <= in[WIDTH-1];
                        seen_one <= 1'b0;
                        count    <= '0;
                        nz       <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg    <= shreg >> 1;
                    work     <= shifted[WIDTH-1:1];
                    seen_one <= seen_one | cur_bit;
                    nz       <= nz | cur_bit;
                    count    <= count + COUNT_W'(1);
                    if (last_shift) begin
                        sign <= sign_r;
                        mag  <= shifted;
                        zero <= ~(nz | cur_bit);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twos_to_signmag.sv
// tb_twos_to_signmag
// Self-checking bench for twos_to_signmag (WIDTH=8). Expected results come
// from plain integer arithmetic on the operand (|x| with the sign taken from
// the MSB), never from the bit-serial algorithm itself.

module tb_twos_to_signmag;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             sign;
    logic [WIDTH-1:0] mag;
    logic             zero;

    int test_count;
    int fail_count;

    twos_to_signmag #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .mag       (mag),
        .zero      (zero)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sign is the MSB, magnitude is |x| as an unsigned 8-bit value
    function automatic logic ref_sign(input logic [WIDTH-1:0] x);
        return (int'(x) >= 128);
    endfunction

    function automatic logic [WIDTH-1:0] ref_mag(input logic [WIDTH-1:0] x);
        int v;
        v = int'(x);
        if (v >= 128) v = 256 - v;
        return WIDTH'(v);
    endfunction

    function automatic logic ref_zero(input logic [WIDTH-1:0] x);
        return (int'(x) == 0);
    endfunction

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one operand from IDLE (called at posedge+1), then wait a bounded time for out_valid
    task automatic applyStimulus(input logic [WIDTH-1:0] operand, output int latency);
        in_data  = operand;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        latency  = 0;
        while (!out_valid && latency < 20) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    // Compare the published result against the reference model
    task automatic checkResult(input string tag, input logic [WIDTH-1:0] operand, input int latency);
        checkOutput({tag, "_latency"}, 32'(latency), 32'd8);
        checkOutput({tag, "_sign"}, 32'(sign), 32'(ref_sign(operand)));
        checkOutput({tag, "_mag"},  32'(mag),  32'(ref_mag(operand)));
        checkOutput({tag, "_zero"}, 32'(zero), 32'(ref_zero(operand)));
    endtask

    // Consume the result and confirm the block is back in IDLE on the next cycle
    task automatic finishOp(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_ovalid_after"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_iready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] directed [7];
        logic [WIDTH-1:0] b2b_ops [3];
        logic [WIDTH-1:0] op;
        int               lat;
        int               accept_cycle [3];
        logic             res_sign [3];
        logic [WIDTH-1:0] res_mag [3];
        int               n_acc;
        int               n_res;

        test_count = 0;
        fail_count = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sign",      32'(sign),      32'd0);
        checkOutput("reset_mag",       32'(mag),       32'd0);
        checkOutput("reset_zero",      32'(zero),      32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed operands including boundaries
        directed[0] = 8'h05; directed[1] = 8'hFB; directed[2] = 8'hFF; directed[3] = 8'h81;
        directed[4] = 8'h80; directed[5] = 8'h00; directed[6] = 8'h7F;
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("dir%0d_in_ready", i), 32'(in_ready), 32'd1);
            applyStimulus(directed[i], lat);
            checkResult($sformatf("dir%0d_%02h", i, directed[i]), directed[i], lat);
            finishOp($sformatf("dir%0d", i));
        end

        // Backpressure with ignored in_valid pulses during SHIFT and DONE
        in_data  = 8'h81;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_in_ready_shift", 32'(in_ready), 32'd0);
        in_data  = 8'h33;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 3;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkResult("bp_81", 8'h81, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 0);
            in_data  = 8'h33;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checkOutput($sformatf("bp_hold%0d_out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_hold%0d_in_ready", i),  32'(in_ready),  32'd0);
            checkOutput($sformatf("bp_hold%0d_sign", i),      32'(sign),      32'd1);
            checkOutput($sformatf("bp_hold%0d_mag", i),       32'(mag),       32'h7F);
        end
        finishOp("bp");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_not_queued_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_not_queued_in_ready",  32'(in_ready),  32'd1);

        // Reset mid-operation: previous result holds during SHIFT, then reset clears everything
        in_data  = 8'hFB;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstmid_mag_held",  32'(mag),  32'h7F);
        checkOutput("rstmid_sign_held", 32'(sign), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rstmid_sign",      32'(sign),      32'd0);
        checkOutput("rstmid_mag",       32'(mag),       32'd0);
        checkOutput("rstmid_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstmid_no_pulse", 32'(out_valid), 32'd0);
        applyStimulus(8'h02, lat);
        checkResult("rstmid_02", 8'h02, lat);
        finishOp("rstmid");

        // Randomized operands against the reference model
        for (int i = 0; i < 20; i++) begin
            op = WIDTH'($urandom_range(0, 255));
            applyStimulus(op, lat);
            checkResult($sformatf("rand%0d_%02h", i, op), op, lat);
            finishOp($sformatf("rand%0d", i));
        end

        // Back-to-back with both handshakes held high
        b2b_ops[0] = 8'hFE; b2b_ops[1] = 8'h03; b2b_ops[2] = 8'h80;
        n_acc = 0;
        n_res = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n_res < 3; cyc++) begin
            if (out_valid) begin
                res_sign[n_res] = sign;
                res_mag[n_res]  = mag;
                n_res++;
            end
            if (in_ready) begin
                if (n_acc < 3) begin
                    in_data  = b2b_ops[n_acc];
                    in_valid = 1'b1;
                    accept_cycle[n_acc] = cyc + 1;
                    n_acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b_result_count", 32'(n_res), 32'd3);
        checkOutput("b2b_accept_count", 32'(n_acc), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < n_res) begin
                checkOutput($sformatf("b2b%0d_sign", i), 32'(res_sign[i]), 32'(ref_sign(b2b_ops[i])));
                checkOutput($sformatf("b2b%0d_mag", i),  32'(res_mag[i]),  32'(ref_mag(b2b_ops[i])));
            end
        end
        if (n_acc == 3) begin
            checkOutput("b2b_spacing01", 32'(accept_cycle[1] - accept_cycle[0]), 32'd10);
            checkOutput("b2b_spacing12", 32'(accept_cycle[2] - accept_cycle[1]), 32'd10);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
